// File: rtl/saturn_pkg.sv
// Shared Saturn core types: nibble, default address width, prefetch FSM states.
package saturn_pkg;

  localparam int unsigned SATURN_ADDR_W = 20;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } pfq_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/saturn_prefetch_queue_if.sv
// Memory-bus and ibus signals of the Saturn prefetch queue.
interface saturn_prefetch_queue_if
  import saturn_pkg::*;
#(
  parameter int unsigned ADDR_W      = SATURN_ADDR_W,
  parameter int unsigned BUS_NIBBLES = 4,
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned OUT_NIBBLES = 8
) ();

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [ADDR_W-1:0]        bus_addr_o;
  logic                     bus_rd_o;
  logic [4*BUS_NIBBLES-1:0] bus_data_in;
  logic                     bus_ack_in;
  logic [ADDR_W-1:0]        ibus_addr_in;
  logic                     ibus_flush_q_in;
  logic                     ibus_consume_in;
  logic [4:0]               ibus_size_in;
  logic [4*OUT_NIBBLES-1:0] ibus_pre_fetched_opcode_o;
  logic [CNT_W-1:0]         ibus_valid_cnt_o;
  logic [ADDR_W-1:0]        ibus_addr_o;
  logic                     ibus_ready_o;

  // The prefetch queue itself.
  modport master (
    output bus_addr_o, bus_rd_o,
    input  bus_data_in, bus_ack_in,
    input  ibus_addr_in, ibus_flush_q_in, ibus_consume_in, ibus_size_in,
    output ibus_pre_fetched_opcode_o, ibus_valid_cnt_o, ibus_addr_o, ibus_ready_o
  );

  // Memory and decoder side.
  modport slave (
    input  bus_addr_o, bus_rd_o,
    output bus_data_in, bus_ack_in,
    output ibus_addr_in, ibus_flush_q_in, ibus_consume_in, ibus_size_in,
    input  ibus_pre_fetched_opcode_o, ibus_valid_cnt_o, ibus_addr_o, ibus_ready_o
  );

endinterface

// File: rtl/saturn_nibble_shifter.sv
// Next queue image: drop `shift` head nibbles, then append a bus word
// (minus `ins_skip` leading nibbles) at position `ins_pos`.
module saturn_nibble_shifter
  import saturn_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned BUS_NIBBLES = 4,
  parameter int unsigned SHIFT_W     = 5,
  parameter int unsigned POS_W       = 5,
  parameter int unsigned SKIP_W      = 2
) (
  input  logic [4*QUEUE_DEPTH-1:0] queue,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic [4*BUS_NIBBLES-1:0] word,
  input  logic                     ins_en,
  input  logic [POS_W-1:0]         ins_pos,
  input  logic [SKIP_W-1:0]        ins_skip,
  output logic [4*QUEUE_DEPTH-1:0] queue_c
);

  always_comb begin
    int unsigned src;
    int unsigned off;
    nibble_t     nib;
    queue_c = '0;
    src     = 0;
    off     = 0;
    nib     = '0;
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      src = i + 32'(shift);
      off = i - 32'(ins_pos) + 32'(ins_skip);
      nib = '0;
      if (src < QUEUE_DEPTH) nib = queue[src*4 +: 4];
      // Entries past the surviving count are zero, so insertion simply overrides.
      if (ins_en && (i >= 32'(ins_pos)) && (off < BUS_NIBBLES)) nib = word[off*4 +: 4];
      queue_c[i*4 +: 4] = nib;
    end
  end

endmodule

// File: rtl/saturn_prefetch_queue.sv
// Saturn instruction prefetch queue: fetches aligned bus words into a nibble
// queue and presents an opcode window. Optional SATURN_PFQ_PERF_EN adds read/discard counters.
module saturn_prefetch_queue
  import saturn_pkg::*;
#(
  parameter int unsigned ADDR_W      = SATURN_ADDR_W,
  parameter int unsigned BUS_NIBBLES = 4,
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned OUT_NIBBLES = 8
) (
  input  logic clk_in,
  input  logic reset_in,
  saturn_prefetch_queue_if.master bus
`ifdef SATURN_PFQ_PERF_EN
  ,
  output logic [15:0] perf_reads_o,
  output logic [15:0] perf_discards_o
`endif
);

  localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned SKIP_W = (BUS_NIBBLES > 1) ? $clog2(BUS_NIBBLES) : 1;
  localparam int unsigned Q_W    = 4 * QUEUE_DEPTH;

  pfq_state_e        state_q;
  logic [Q_W-1:0]    queue_q;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] head_q;
  logic [ADDR_W-1:0] fetch_q;
  logic [SKIP_W-1:0] skip_q;
  logic              rd_q;
  logic              ready_q;
`ifdef SATURN_PFQ_PERF_EN
  logic [15:0]       reads_q;
  logic [15:0]       discards_q;
`endif

  logic              consume_ok_c;
  logic              ack_take_c;
  logic              free_ok_c;
  logic [4:0]        shift_c;
  logic [CNT_W-1:0]  ins_pos_c;
  logic [CNT_W-1:0]  next_count_c;
  logic [Q_W-1:0]    next_queue_c;

  // Consume/ack qualification; free space is judged on the pre-consume count.
  always_comb begin
    consume_ok_c = bus.ibus_consume_in && !bus.ibus_flush_q_in &&
                   (bus.ibus_size_in != 5'd0) && (32'(bus.ibus_size_in) <= 32'(count_q));
    ack_take_c   = (state_q == REQ) && bus.bus_ack_in && !bus.ibus_flush_q_in;
    free_ok_c    = (32'(QUEUE_DEPTH) - 32'(count_q)) >= 32'(BUS_NIBBLES);
    shift_c      = consume_ok_c ? bus.ibus_size_in : 5'd0;
    ins_pos_c    = count_q - CNT_W'(shift_c);
    next_count_c = ins_pos_c +
                   (ack_take_c ? (CNT_W'(BUS_NIBBLES) - CNT_W'(skip_q)) : CNT_W'(0));
  end

  saturn_nibble_shifter #(
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .BUS_NIBBLES (BUS_NIBBLES),
    .SHIFT_W     (5),
    .POS_W       (CNT_W),
    .SKIP_W      (SKIP_W)
  ) u_shifter (
    .queue    (queue_q),
    .shift    (shift_c),
    .word     (bus.bus_data_in),
    .ins_en   (ack_take_c),
    .ins_pos  (ins_pos_c),
    .ins_skip (skip_q),
    .queue_c  (next_queue_c)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      queue_q    <= '0;
      count_q    <= '0;
      head_q     <= '0;
      fetch_q    <= '0;
      skip_q     <= '0;
      rd_q       <= 1'b0;
      ready_q    <= 1'b0;
`ifdef SATURN_PFQ_PERF_EN
      reads_q    <= '0;
      discards_q <= '0;
`endif
    end else if (bus.ibus_flush_q_in) begin
      queue_q <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      head_q  <= bus.ibus_addr_in;
      fetch_q <= bus.ibus_addr_in & ~ADDR_W'(BUS_NIBBLES - 1);
      skip_q  <= SKIP_W'(bus.ibus_addr_in);
      // An outstanding read must still complete on the bus; its data is dropped.
      if ((state_q != IDLE) && !bus.bus_ack_in) begin
        state_q <= DRAIN;
        rd_q    <= 1'b1;
      end else begin
        state_q <= IDLE;
        rd_q    <= 1'b0;
      end
`ifdef SATURN_PFQ_PERF_EN
      if ((state_q != IDLE) && bus.bus_ack_in) begin
        reads_q    <= sat_inc16(reads_q);
        discards_q <= sat_inc16(discards_q);
      end
`endif
    end else begin
      queue_q <= next_queue_c;
      count_q <= next_count_c;
      head_q  <= head_q + ADDR_W'(shift_c);
      ready_q <= (32'(next_count_c) >= 32'(OUT_NIBBLES));
      unique case (state_q)
        IDLE: begin
          if (free_ok_c) begin
            state_q <= REQ;
            rd_q    <= 1'b1;
          end
        end
        REQ: begin
          if (bus.bus_ack_in) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            fetch_q <= fetch_q + ADDR_W'(BUS_NIBBLES);
            skip_q  <= '0;
`ifdef SATURN_PFQ_PERF_EN
            reads_q <= sat_inc16(reads_q);
`endif
          end
        end
        DRAIN: begin
          if (bus.bus_ack_in) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
`ifdef SATURN_PFQ_PERF_EN
            reads_q    <= sat_inc16(reads_q);
            discards_q <= sat_inc16(discards_q);
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          rd_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_addr_o                = fetch_q;
  assign bus.bus_rd_o                  = rd_q;
  assign bus.ibus_pre_fetched_opcode_o = queue_q[4*OUT_NIBBLES-1:0];
  assign bus.ibus_valid_cnt_o          = count_q;
  assign bus.ibus_addr_o               = head_q;
  assign bus.ibus_ready_o              = ready_q;
`ifdef SATURN_PFQ_PERF_EN
  assign perf_reads_o    = reads_q;
  assign perf_discards_o = discards_q;
`endif

endmodule

// File: doc/saturn_prefetch_queue.md
Name: saturn_prefetch_queue

Overview:
Parametrised instruction prefetch queue for the Saturn core. It sits between the core's ibus and the external word-wide memory bus. It reads aligned bus words and unpacks them into a nibble queue. It presents a window of up to OUT_NIBBLES pre-fetched opcode nibbles to the decoder. Generalises the first-generation bus controller's fixed 16-bit fetch with these additions:
- configurable bus width and queue depth
- a memory ready/ack handshake
- variable-length consume
- discard of in-flight reads on flush

Parameters:
ADDR_W, 20, nibble address width
BUS_NIBBLES, 4, nibbles per bus word (power of 2; 4 = 16-bit bus)
QUEUE_DEPTH, 16, queue capacity in nibbles (power of 2, >= 2*BUS_NIBBLES, >= OUT_NIBBLES)
OUT_NIBBLES, 8, width of opcode window in nibbles

Ports:
clk_in  in  1  clock
reset_in  in  1  synchronous active-high reset
bus_addr_o  out  ADDR_W  nibble address of requested word; low log2(BUS_NIBBLES) bits always 0
bus_rd_o  out  1  read request; held until bus_ack_in
bus_data_in  in  4*BUS_NIBBLES  read data; nibble at bus_addr_o+k in bits [4k+3:4k]
bus_ack_in  in  1  data valid this cycle; completes the read
ibus_addr_in  in  ADDR_W  new program counter
ibus_flush_q_in  in  1  flush queue and restart at ibus_addr_in
ibus_consume_in  in  1  decoder consumes ibus_size_in nibbles
ibus_size_in  in  5  nibbles consumed (1..OUT_NIBBLES)
ibus_pre_fetched_opcode_o  out  4*OUT_NIBBLES  queue head; nibble at ibus_addr_o in [3:0]
ibus_valid_cnt_o  out  log2(QUEUE_DEPTH)+1  valid nibbles in queue
ibus_addr_o  out  ADDR_W  address of head nibble
ibus_ready_o  out  1  ibus_valid_cnt_o >= OUT_NIBBLES

Behaviour:
Reset:
- All outputs 0.
- Queue empty, state IDLE.
- Fetch address and head address 0.

FSM states:
- IDLE → REQ when free space (QUEUE_DEPTH - count) >= BUS_NIBBLES and no flush this cycle.
- REQ drives bus_rd_o=1 with a stable bus_addr_o.
- REQ on ack:
  - Unpacks the word into the queue tail, skipping `skip` leading nibbles.
  - Sets skip=0 and advances fetch address by BUS_NIBBLES (modulo 2^ADDR_W).
  - Goes to IDLE.
  - May re-request next cycle, so sustained throughput is one word per 2 cycles minimum.
- Flush while in REQ with no ack → DRAIN. DRAIN keeps bus_rd_o=1 until ack, discards the data, then goes to IDLE.
- Flush in the same cycle as ack → the acked data is discarded.

Flush (highest priority):
- Count=0, head=ibus_addr_in.
- Fetch address = ibus_addr_in aligned down to BUS_NIBBLES.
- skip = ibus_addr_in mod BUS_NIBBLES.
- Consume in the same cycle is ignored.
- Earliest bus_rd_o is the cycle after the flush.

Consume:
- If ibus_size_in <= count: count -= size, head += size (wraps), queue shifts.
- If ibus_size_in > count or ibus_size_in = 0: ignored.
- Consume and ack in the same cycle:
  - Both apply.
  - New nibbles land after the remaining ones.
  - The free-space check uses the pre-consume count.

Output timing:
- All outputs are registered.
- Nibbles from an ack are visible on ibus_pre_fetched_opcode_o the next cycle.
- Window nibbles at positions >= count read as 0.

Overflow: cannot occur, because a request is issued only with room for a full word.

Reset mid-read: bus_rd_o drops the next edge, and a late ack while IDLE is ignored.

Optional Feature:
SATURN_PFQ_PERF_EN
- When defined, adds two output ports:
  - perf_reads_o[15:0] counts completed bus reads.
  - perf_discards_o[15:0] counts reads discarded by DRAIN or flush-with-ack.
- Both counters saturate at 0xFFFF and clear on reset.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Decomposition:
Shared package saturn_pkg:
- nibble typedef (4-bit)
- ADDR_W default constant
- prefetch FSM state enum {IDLE, REQ, DRAIN}

One sub-module, saturn_nibble_shifter, is natural: a combinational barrel shift that handles both consume-left-shift and tail insertion at an offset.

Test Plan:
Memory model: the word at aligned address A holds nibbles ((A+k)&0xF), and ack is given 2 cycles after bus_rd_o. Default parameters.
- Flush to 0x00000 → reads at 0x00000, 0x00004; opcode_o=0x76543210, ibus_ready_o=1, ibus_addr_o=0x00000.
- Flush to 0x00003 → first read at 0x00000 delivers 1 nibble; head nibble 0x3, valid_cnt_o=1 after the first ack, 5 after the second.
- Queue full (16), consume 5 → addr_o +5, head nibble (addr+5)&F, valid_cnt_o=11 next cycle; a new read is issued since free space is 5 >= 4.
- Flush while bus_rd_o is pending with ack delayed 4 cycles → DRAIN; the old data is discarded, the next read goes to the new aligned address, and with PERF_EN perf_discards_o=1.
- Flush to 0xFFFFE, consume across the boundary → fetch addresses 0xFFFFC then 0x00000; ibus_addr_o wraps to 0x00001 after consuming 3.
- Assert reset_in mid-REQ, then give a stray ack while IDLE → all outputs 0, queue empty, ack ignored.
